iq_boxcar_decim: RTL and testbench
==================================

// Module: iq_boxcar_decim
// PURPOSE
//  Consumes the interleaved I/Q stream from the near-IQ downconverter: one 16-bit sample per
//  clk, I and Q alternating, with trig marking phase. Splits the stream into I and Q, sums each
//  over dec_n consecutive I/Q pairs (boxcar, decimation by dec_n), then shifts and saturates.
//  Emits one I/Q result pair per block with a one-cycle strobe, for the feedback/readout stages.
// PARAMETERS
//  iw     16  input sample width (signed)
//  nw     12  width of dec_n; accumulator width aw = iw+nw = 28
//  ow     18  output width (signed, saturated)
// PORTS
//  clk       in   1      system clock
//  rst       in   1      synchronous reset, active high
//  iq_data   in   iw     interleaved I/Q sample, signed
//  iq_gate   in   1      sample valid; when 0 the cycle is ignored
//  iq_trig   in   1      0: sample is I, 1: sample is Q (pair = I then Q)
//  time_err  in   1      upstream timing error; aborts the current block
//  dec_n     in   nw     pairs per block, unsigned; 0 is treated as 1
//  shift     in   4      arithmetic right shift applied to sums, 0..15
//  i_out     out  ow     decimated I, signed
//  q_out     out  ow     decimated Q, signed
//  out_valid out  1      one-cycle strobe: i_out/q_out updated
//  sat_flag  out  1      sticky: saturation occurred; cleared only by rst
//  phase_err out  1      sticky: trig sequence violated; cleared only by rst
// BEHAVIOUR
//  Reset: all outputs 0; accumulators 0; pair count 0; state SYNC.
//  FSM (advances only on cycles with iq_gate=1; gate=0 cycles hold all state):
//   SYNC: wait for a gated sample with trig=0. That sample seeds acc_i and goes to WANT_Q.
//   WANT_Q: trig=1: acc_q += data, pair count += 1, go to WANT_I.
//           trig=0: phase error.
//   WANT_I: trig=0: acc_i += data, go to WANT_Q.
//           trig=1: phase error.
//   Phase error: set phase_err, discard acc_i/acc_q and count, go to SYNC.
//   No block is emitted for the discarded data.
//  Block end: the Q sample that makes count == n_lat (latched dec_n, 0 -> 1) ends the block.
//   - The sums of that block, including this Q, are captured into dump registers on the next edge.
//   - In that same edge the accumulators and count restart at 0.
//   - The FSM enters WANT_I, so back-to-back blocks lose no samples.
//  dec_n and shift are latched at block start (first I after reset, SYNC or block end).
//   Changes mid-block take effect on the next block.
//  time_err=1 on any cycle, gated or not: same as phase error, but phase_err is not set.
//   The FSM goes to SYNC. time_err has priority over a simultaneous block end, so no out_valid.
//  Arithmetic: acc is aw bits, signed. Worst-case sum 4095*(-32768) fits without wrap.
//   - Output stage: y = dump >>> shift_lat (arithmetic).
//   - Saturate y to ow bits: clamp to +(2^(ow-1)-1) or -(2^(ow-1)); set sat_flag when clamping.
//   - I and Q are saturated independently.
//  Latency: final Q sample on edge N. Dump registers load at N+1. i_out, q_out and out_valid are
//   registered at N+2. out_valid is high for exactly cycle N+2. i_out/q_out hold until the next strobe.
//  rst mid-block: partial sums are dropped and no out_valid follows. A strobe already in the
//   pipeline is cancelled.
//  Throughput: minimum block spacing is 2*max(dec_n,1) cycles (dec_n=1 gives a strobe every 2 cycles).
// CONFIGURATION
//  IQ_BOXCAR_ROUND_EN defined: before the shift, add 2^(shift_lat-1) to the sum when shift_lat>0
//   (round half up). The addition is done at aw+1 bits, so it cannot overflow.
//  Not defined: plain truncation toward -inf (arithmetic shift only). Latency is the same either way.
// TESTING
//  1 dec_n=4, shift=2: constant I=1000, Q=-500, gate=1, alternating trig
//    -> out_valid every 8 cycles, i_out=1000, q_out=-500.
//  2 dec_n=1, shift=0: I=32767, Q=-32768
//    -> strobe every 2 cycles, outputs match input; sat_flag=0.
//  3 dec_n=4095, shift=0: all I=32767
//    -> i_out=131071 (saturated), sat_flag=1 stays high after further blocks.
//  4 dec_n=2, shift=0: inject trig=0,0 mid-block
//    -> phase_err=1, no strobe for that block; next I/I/Q.. resync gives a correct sum 2 pairs later.
//  5 dec_n=3: gate=0 for 5 cycles mid-block, then time_err pulse on the block-ending Q
//    -> gaps add no samples; no strobe for the aborted block; phase_err=0.
//  6 shift=1, I sum=3 (dec_n=1, I=3)
//    -> i_out=2 with IQ_BOXCAR_ROUND_EN, i_out=1 without; also I=-3 -> -1 and -2 respectively.

Source files
------------

// File: rtl/iq_boxcar_decim.sv
// ---------------------------------------------------------------------------
// iq_boxcar_decim
//
// Boxcar decimator for an interleaved I/Q sample stream. Samples arrive one
// per clk (when iq_gate=1) as I, Q, I, Q ... with iq_trig marking the phase
// (0 = I, 1 = Q). Each channel is summed over n_lat consecutive I/Q pairs.
// The sums are then arithmetically shifted right and saturated to ow bits.
// One I/Q result pair is emitted per block, together with a one-cycle strobe.
//
// Optional build macro:
//   IQ_BOXCAR_ROUND_EN  When defined, 2^(shift-1) is added before the shift
//                       (round half up). When undefined, the output stage
//                       uses plain arithmetic shift (truncation toward -inf).
//
// Ports
//   clk        system clock
//   rst        synchronous reset, active high
//   iq_data    interleaved I/Q sample, signed, iw bits
//   iq_gate    sample valid; cycles with iq_gate=0 leave the FSM untouched
//   iq_trig    sample phase: 0 = I, 1 = Q
//   time_err   upstream timing error; aborts the current block on any cycle
//   dec_n      pairs per block (0 behaves as 1), latched at block start
//   shift      arithmetic right shift 0..15, latched at block start
//   i_out      decimated I, signed, ow bits, held between strobes
//   q_out      decimated Q, signed, ow bits, held between strobes
//   out_valid  one-cycle strobe marking new i_out/q_out
//   sat_flag   sticky: an output was clamped (cleared by rst only)
//   phase_err  sticky: I/Q phase sequence broken (cleared by rst only)
// ---------------------------------------------------------------------------
module iq_boxcar_decim #(
    parameter int iw = 16,
    parameter int nw = 12,
    parameter int ow = 18
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [iw-1:0] iq_data,
    input  logic                 iq_gate,
    input  logic                 iq_trig,
    input  logic                 time_err,
    input  logic        [nw-1:0] dec_n,
    input  logic        [3:0]    shift,
    output logic signed [ow-1:0] i_out,
    output logic signed [ow-1:0] q_out,
    output logic                 out_valid,
    output logic                 sat_flag,
    output logic                 phase_err
);

    localparam int aw = iw + nw;

    // Saturation limits expressed at the aw+1 bit width of the shifted sum.
    localparam logic signed [aw:0] SAT_MAX = {{(aw-ow+2){1'b0}}, {(ow-1){1'b1}}};
    localparam logic signed [aw:0] SAT_MIN = {{(aw-ow+2){1'b1}}, {(ow-1){1'b0}}};

    typedef enum logic [1:0] {
        SYNC   = 2'd0,
        WANT_Q = 2'd1,
        WANT_I = 2'd2
    } state_t;

    state_t               r_state, w_state_next;
    logic signed [aw-1:0] r_acc_i, r_acc_q;
    logic signed [aw-1:0] w_acc_i_next, w_acc_q_next;
    logic signed [aw-1:0] w_base_i, w_base_q, w_data_ext;
    logic        [nw-1:0] r_cnt, w_cnt_next, w_base_cnt, w_cnt_inc;
    logic        [nw-1:0] r_n_lat, w_n_lat_next, w_dec_n_eff;
    logic        [3:0]    r_sh_lat, w_sh_lat_next;
    logic                 r_end_pend, w_end_next;
    logic                 w_perr_next;

    // Dump stage: one entry per channel (0 = I, 1 = Q).
    logic signed [aw-1:0] r_dump [2];
    logic        [3:0]    r_dump_sh;
    logic                 r_dump_vld;
    logic signed [ow-1:0] w_sat  [2];
    logic        [1:0]    w_clip;

    assign w_data_ext  = {{nw{iq_data[iw-1]}}, iq_data};
    assign w_dec_n_eff = (dec_n == '0) ? nw'(1) : dec_n;

    // The edge after a block-ending Q hands the finished sums to the dump
    // stage. On that same edge the accumulators restart from zero, yet a new
    // I may already be arriving, so it is added onto a zero base instead of
    // the old sum. This keeps back-to-back blocks free of dropped samples.
    assign w_base_i   = r_end_pend ? '0 : r_acc_i;
    assign w_base_q   = r_end_pend ? '0 : r_acc_q;
    assign w_base_cnt = r_end_pend ? '0 : r_cnt;
    assign w_cnt_inc  = w_base_cnt + nw'(1);

    // ------------------------------------------------------------------
    // Phase tracking FSM and accumulators
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next  = r_state;
        w_acc_i_next  = w_base_i;
        w_acc_q_next  = w_base_q;
        w_cnt_next    = w_base_cnt;
        w_n_lat_next  = r_n_lat;
        w_sh_lat_next = r_sh_lat;
        w_end_next    = 1'b0;
        w_perr_next   = phase_err;

        if (time_err) begin
            // Abort wins over everything, including a block end this cycle.
            w_state_next = SYNC;
            w_acc_i_next = '0;
            w_acc_q_next = '0;
            w_cnt_next   = '0;
        end else if (iq_gate) begin
            unique case (r_state)
                SYNC: begin
                    if (!iq_trig) begin
                        w_acc_i_next  = w_data_ext;
                        w_acc_q_next  = '0;
                        w_cnt_next    = '0;
                        w_n_lat_next  = w_dec_n_eff;
                        w_sh_lat_next = shift;
                        w_state_next  = WANT_Q;
                    end
                end
                WANT_Q: begin
                    if (iq_trig) begin
                        w_acc_q_next = w_base_q + w_data_ext;
                        w_cnt_next   = w_cnt_inc;
                        w_end_next   = (w_cnt_inc == r_n_lat);
                        w_state_next = WANT_I;
                    end else begin
                        w_perr_next  = 1'b1;
                        w_acc_i_next = '0;
                        w_acc_q_next = '0;
                        w_cnt_next   = '0;
                        w_state_next = SYNC;
                    end
                end
                WANT_I: begin
                    if (!iq_trig) begin
                        // A zero pair count in WANT_I only happens right after
                        // a block end, so this I opens a new block.
                        if (w_base_cnt == '0) begin
                            w_n_lat_next  = w_dec_n_eff;
                            w_sh_lat_next = shift;
                        end
                        w_acc_i_next = w_base_i + w_data_ext;
                        w_state_next = WANT_Q;
                    end else begin
                        w_perr_next  = 1'b1;
                        w_acc_i_next = '0;
                        w_acc_q_next = '0;
                        w_cnt_next   = '0;
                        w_state_next = SYNC;
                    end
                end
                default: begin
                    w_state_next = SYNC;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= SYNC;
            r_acc_i    <= '0;
            r_acc_q    <= '0;
            r_cnt      <= '0;
            r_n_lat    <= nw'(1);
            r_sh_lat   <= '0;
            r_end_pend <= 1'b0;
            phase_err  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_acc_i    <= w_acc_i_next;
            r_acc_q    <= w_acc_q_next;
            r_cnt      <= w_cnt_next;
            r_n_lat    <= w_n_lat_next;
            r_sh_lat   <= w_sh_lat_next;
            r_end_pend <= w_end_next;
            phase_err  <= w_perr_next;
        end
    end

    // ------------------------------------------------------------------
    // Dump stage: freezes the finished sums together with the shift that
    // was latched for that block, since a new block may relatch shift on
    // this very edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dump[0]  <= '0;
            r_dump[1]  <= '0;
            r_dump_sh  <= '0;
            r_dump_vld <= 1'b0;
        end else begin
            r_dump_vld <= r_end_pend;
            if (r_end_pend) begin
                r_dump[0] <= r_acc_i;
                r_dump[1] <= r_acc_q;
                r_dump_sh <= r_sh_lat;
            end
        end
    end

    // ------------------------------------------------------------------
    // Shift, optional rounding and saturation, per channel
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_chan
            logic signed [aw:0] w_ext;
            logic signed [aw:0] w_sum;
            logic signed [aw:0] w_y;

            // One extra bit so the rounding constant cannot overflow.
            assign w_ext = {r_dump[gi][aw-1], r_dump[gi]};
`ifdef IQ_BOXCAR_ROUND_EN
            logic signed [aw:0] w_rnd;
            assign w_rnd = (r_dump_sh == 4'd0) ? '0
                         : ((aw+1)'(1) << (r_dump_sh - 4'd1));
            assign w_sum = w_ext + w_rnd;
`else
            assign w_sum = w_ext;
`endif
            assign w_y        = w_sum >>> r_dump_sh;
            assign w_clip[gi] = (w_y > SAT_MAX) || (w_y < SAT_MIN);
            assign w_sat[gi]  = (w_y > SAT_MAX) ? SAT_MAX[ow-1:0]
                              : (w_y < SAT_MIN) ? SAT_MIN[ow-1:0]
                              : w_y[ow-1:0];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            i_out     <= '0;
            q_out     <= '0;
            out_valid <= 1'b0;
            sat_flag  <= 1'b0;
        end else begin
            out_valid <= r_dump_vld;
            if (r_dump_vld) begin
                i_out <= w_sat[0];
                q_out <= w_sat[1];
                if (|w_clip) begin
                    sat_flag <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_iq_boxcar_decim.sv
// ---------------------------------------------------------------------------
// Testbench for iq_boxcar_decim. A table of single-block vectors is applied
// back to back, followed by hand-written sequences for phase errors, gaps,
// time_err aborts, reset cancellation, mid-block parameter changes and long
// saturating blocks. Expected results are queued when the final Q of a block
// is driven and checked when the strobe appears, including its cycle.
// ---------------------------------------------------------------------------
module tb_iq_boxcar_decim;

    logic                clk = 1'b0;
    logic                rst;
    logic signed [15:0]  iq_data;
    logic                iq_gate;
    logic                iq_trig;
    logic                time_err;
    logic        [11:0]  dec_n;
    logic        [3:0]   shift;
    logic signed [17:0]  i_out;
    logic signed [17:0]  q_out;
    logic                out_valid;
    logic                sat_flag;
    logic                phase_err;

    iq_boxcar_decim dut (
        .clk       (clk),
        .rst       (rst),
        .iq_data   (iq_data),
        .iq_gate   (iq_gate),
        .iq_trig   (iq_trig),
        .time_err  (time_err),
        .dec_n     (dec_n),
        .shift     (shift),
        .i_out     (i_out),
        .q_out     (q_out),
        .out_valid (out_valid),
        .sat_flag  (sat_flag),
        .phase_err (phase_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int  i;
        int  q;
        bit  sat;
        longint cyc;
    } exp_t;

    typedef struct {
        logic [11:0] dec_n;
        logic [3:0]  sh;
        int          i_val;
        int          q_val;
        int          exp_i;
        int          exp_q;
        bit          exp_sat;
    } row_t;

    exp_t   sb[$];
    row_t   tbl[6];
    longint cyc = 0;
    int     errors = 0;
    int     checks = 0;
    int     n_strobe = 0;
    bit     sat_model = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    // Reference output stage: shift, optional round, saturate to 18 bits.
    function automatic void model(input longint sum, input int sh,
                                  output int y, output bit clip);
        longint t;
        t = sum;
`ifdef IQ_BOXCAR_ROUND_EN
        if (sh > 0) t = t + (64'sd1 <<< (sh - 1));
`endif
        t = t >>> sh;
        clip = 1'b0;
        if (t > 131071) begin
            t = 131071;
            clip = 1'b1;
        end else if (t < -131072) begin
            t = -131072;
            clip = 1'b1;
        end
        y = int'(t);
    endfunction

    task automatic push_exp(input int ei, input int eq, input bit esat);
        exp_t e;
        sat_model = sat_model | esat;
        e.i   = ei;
        e.q   = eq;
        e.sat = sat_model;
        e.cyc = cyc + 2;
        sb.push_back(e);
    endtask

    task automatic push_sum(input longint si, input longint sq, input int sh);
        int yi, yq;
        bit ci, cq;
        model(si, sh, yi, ci);
        model(sq, sh, yq, cq);
        push_exp(yi, yq, ci | cq);
    endtask

    // One clock of stimulus; the DUT samples it on the edge inside.
    task automatic send(input bit g, input bit t, input int d, input bit te);
        iq_gate  = g;
        iq_trig  = t;
        iq_data  = 16'(d);
        time_err = te;
        @(posedge clk);
        #1;
        iq_gate  = 1'b0;
        time_err = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) send(1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        iq_gate  = 1'b0;
        time_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst       = 1'b0;
        sat_model = 1'b0;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && out_valid) begin
            n_strobe++;
            $display("strobe cyc=%0d i_out=%0d q_out=%0d sat=%0b perr=%0b",
                     cyc, i_out, q_out, sat_flag, phase_err);
            if (sb.size() == 0) begin
                chk("unexpected_strobe", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("i_out", i_out, e.i);
                chk("q_out", q_out, e.q);
                chk("sat_flag", sat_flag, e.sat);
                chk("strobe_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin : main
        int n;
        int snap;

        tbl[0] = '{12'd4,  4'd2,   1000,   -500,   1000,   -500, 1'b0};
        tbl[1] = '{12'd1,  4'd0,  32767, -32768,  32767, -32768, 1'b0};
        tbl[2] = '{12'd0,  4'd0,      5,     -7,      5,     -7, 1'b0};
`ifdef IQ_BOXCAR_ROUND_EN
        tbl[3] = '{12'd1,  4'd1,      3,     -3,      2,     -1, 1'b0};
        tbl[5] = '{12'd3,  4'd15,-32768,  32767,     -3,      3, 1'b0};
`else
        tbl[3] = '{12'd1,  4'd1,      3,     -3,      1,     -2, 1'b0};
        tbl[5] = '{12'd3,  4'd15,-32768,  32767,     -3,      2, 1'b0};
`endif
        tbl[4] = '{12'd8,  4'd0,  20000, -20000, 131071,-131072, 1'b1};

        rst = 1'b1; iq_data = '0; iq_gate = 1'b0; iq_trig = 1'b0;
        time_err = 1'b0; dec_n = '0; shift = '0;
        do_reset();
        chk("reset_i_out", i_out, 0);
        chk("reset_q_out", q_out, 0);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_sat_flag", sat_flag, 0);
        chk("reset_phase_err", phase_err, 0);

        // Table vectors, blocks back to back.
        for (int r = 0; r < 6; r++) begin
            n = (tbl[r].dec_n == 0) ? 1 : int'(tbl[r].dec_n);
            dec_n = tbl[r].dec_n;
            shift = tbl[r].sh;
            for (int p = 0; p < n; p++) begin
                send(1'b1, 1'b0, tbl[r].i_val, 1'b0);
                send(1'b1, 1'b1, tbl[r].q_val, 1'b0);
            end
            push_exp(tbl[r].exp_i, tbl[r].exp_q, tbl[r].exp_sat);
        end
        idle(6);
        chk("table_phase_err", phase_err, 0);

        // Reset right after a block end cancels the pending strobe.
        dec_n = 12'd1; shift = 4'd0;
        send(1'b1, 1'b0, 5, 1'b0);
        send(1'b1, 1'b1, 5, 1'b0);
        snap = n_strobe;
        do_reset();
        idle(6);
        chk("rst_cancel_strobes", n_strobe, snap);
        chk("rst_clears_sat", sat_flag, 0);

        // Phase error: I Q I I, then a clean 2-pair block after resync.
        dec_n = 12'd2; shift = 4'd0;
        send(1'b1, 1'b0, 10, 1'b0);
        send(1'b1, 1'b1, 20, 1'b0);
        send(1'b1, 1'b0, 10, 1'b0);
        send(1'b1, 1'b0, 10, 1'b0);
        send(1'b1, 1'b0, 1, 1'b0);
        send(1'b1, 1'b1, 2, 1'b0);
        send(1'b1, 1'b0, 3, 1'b0);
        send(1'b1, 1'b1, 4, 1'b0);
        push_sum(4, 6, 0);
        idle(5);
        chk("phase_err_set", phase_err, 1);

        // Gaps plus time_err on the block-ending Q.
        do_reset();
        dec_n = 12'd3; shift = 4'd0;
        snap = n_strobe;
        send(1'b1, 1'b0, 100, 1'b0);
        send(1'b1, 1'b1, 200, 1'b0);
        for (int k = 0; k < 5; k++) send(1'b0, k[0], 999, 1'b0);
        send(1'b1, 1'b0, 100, 1'b0);
        send(1'b1, 1'b1, 200, 1'b0);
        send(1'b1, 1'b0, 100, 1'b0);
        send(1'b1, 1'b1, 200, 1'b1);
        idle(5);
        chk("time_err_no_strobe", n_strobe, snap);
        chk("time_err_no_phase_err", phase_err, 0);

        // Completed block with gated-off cycles inside it.
        send(1'b1, 1'b0, 7, 1'b0);
        for (int k = 0; k < 3; k++) send(1'b0, 1'b1, 12345, 1'b0);
        send(1'b1, 1'b1, -9, 1'b0);
        send(1'b1, 1'b0, 7, 1'b0);
        send(1'b1, 1'b1, -9, 1'b0);
        send(1'b1, 1'b0, 7, 1'b0);
        send(1'b1, 1'b1, -9, 1'b0);
        push_sum(21, -27, 0);
        idle(4);

        // dec_n / shift changes mid-block apply to the following block.
        dec_n = 12'd2; shift = 4'd0;
        send(1'b1, 1'b0, 1, 1'b0);
        dec_n = 12'd5; shift = 4'd3;
        send(1'b1, 1'b1, 1, 1'b0);
        send(1'b1, 1'b0, 1, 1'b0);
        send(1'b1, 1'b1, 1, 1'b0);
        push_sum(2, 2, 0);
        for (int p = 0; p < 5; p++) begin
            send(1'b1, 1'b0, 2, 1'b0);
            send(1'b1, 1'b1, 3, 1'b0);
        end
        push_sum(10, 15, 3);
        idle(5);

        // Longest block at full scale saturates; sat_flag stays sticky.
        do_reset();
        dec_n = 12'd4095; shift = 4'd0;
        for (int p = 0; p < 4095; p++) begin
            send(1'b1, 1'b0, 32767, 1'b0);
            send(1'b1, 1'b1, 0, 1'b0);
        end
        push_sum(longint'(4095) * 32767, 0, 0);
        dec_n = 12'd1;
        send(1'b1, 1'b0, 1, 1'b0);
        send(1'b1, 1'b1, 1, 1'b0);
        push_sum(1, 1, 0);
        idle(6);
        chk("sat_sticky", sat_flag, 1);

        chk("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
